eng_uc_queue: RTL

ENG_UC_QUEUE -- requirements
Module: eng_uc_queue

---
 rtl/eng_uc_queue_if.sv | 30 +++
 rtl/eng_uc_queue.sv | 111 +++++++++++
 2 files changed

// File: rtl/eng_uc_queue_if.sv
// Handshake bundle between a BCP engine queue, its local core and the unit-clause arbiter.
interface eng_uc_queue_if #(
    parameter int LW = 10
);
    logic          core_push;
    logic [LW-1:0] core_lit;
    logic [LW-1:0] uca2eng;
    logic          uca2eng_pop;
    logic          conflict;
    logic          restart;
    logic [LW-1:0] eng2uca_min;
    logic          eng2uca_valid;
    logic          eng2uca_empty;
    logic          uca2eng_full;
    logic [LW-1:0] core_lit_out;
    logic          core_lit_valid;
    logic          overflow;

    modport master (
        output core_push, core_lit, uca2eng, uca2eng_pop, conflict, restart,
        input  eng2uca_min, eng2uca_valid, eng2uca_empty, uca2eng_full,
               core_lit_out, core_lit_valid, overflow
    );

    modport slave (
        input  core_push, core_lit, uca2eng, uca2eng_pop, conflict, restart,
        output eng2uca_min, eng2uca_valid, eng2uca_empty, uca2eng_full,
               core_lit_out, core_lit_valid, overflow
    );
endinterface

// File: rtl/eng_uc_queue.sv
// Per-engine unit-literal queue: buffers implied literals, offers the head to the arbiter.
// Head offer is combinational from state; broadcast echo is one cycle later.
// Full queue drops pushes (sticky overflow); the arbiter pops by broadcasting the head or its negation.
module eng_uc_queue #(
    parameter int UCQ_SIZE  = 16,
    parameter int UC_LENGTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    eng_uc_queue_if.slave bus
);
    localparam int LW = $clog2(UC_LENGTH);
    localparam int PW = $clog2(UCQ_SIZE);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t        state;
    logic [LW-1:0] mem [UCQ_SIZE];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [LW-1:0] core_lit_out_q;
    logic          core_lit_valid_q;
    logic          overflow_q;

    logic [LW-1:0] head;
    logic          not_empty, full, run, live;
    logic          hit_pos, hit_neg, push_req, push_acc, push_drop, pop_acc;

    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);
    assign full      = (count == CW'(UCQ_SIZE));
    assign run       = (state == RUN);
    // conflict wins over any queue traffic in the same cycle
    assign live      = run && !bus.conflict;

    assign hit_pos   = bus.uca2eng_pop && not_empty && (bus.uca2eng == head);
    assign hit_neg   = bus.uca2eng_pop && not_empty && (bus.uca2eng == LW'(-head));
    assign push_req  = live && bus.core_push && (bus.core_lit != '0);
    // fullness is judged on the registered count, so a same-cycle pop never makes room
    assign push_acc  = push_req && !full;
    assign push_drop = push_req && full;
    assign pop_acc   = live && (hit_pos || hit_neg);

    assign bus.eng2uca_min    = not_empty ? head : '0;
    assign bus.eng2uca_valid  = run && not_empty && !(hit_pos || hit_neg);
    assign bus.eng2uca_empty  = !not_empty;
    assign bus.uca2eng_full   = full;
    assign bus.core_lit_out   = core_lit_out_q;
    assign bus.core_lit_valid = core_lit_valid_q;
    assign bus.overflow       = overflow_q;

    // Storage is deliberately left out of reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= bus.core_lit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= RUN;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            core_lit_out_q   <= '0;
            core_lit_valid_q <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            core_lit_valid_q <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.conflict) begin
                        state <= FLUSH;
                    end else begin
                        if (bus.uca2eng_pop) begin
                            core_lit_out_q   <= bus.uca2eng;
                            core_lit_valid_q <= 1'b1;
                        end
                        if (push_acc) begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                        if (pop_acc) begin
                            rd_ptr <= rd_ptr + PW'(1);
                        end
                        if (push_acc && !pop_acc) begin
                            count <= count + CW'(1);
                        end else if (!push_acc && pop_acc) begin
                            count <= count - CW'(1);
                        end
                        if (push_drop) begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                    state  <= HALT;
                end
                HALT: begin
                    if (bus.restart && !bus.conflict) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
